// File: rtl/signed_add_arbiter.sv
// Two requesters share one signed adder through a round-robin arbiter.
// A single-entry result register with valid/ready handshake feeds a saturating overflow counter.
module signed_add_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_overflow,
    output logic             res_id,
    input  logic             ovf_clr,
    output logic [3:0]       ovf_count
);

    logic [1:0]       valid_vec;
    logic [1:0]       grant;
    logic [1:0]       ready_vec;
    logic [1:0]       xfer_vec;
    logic             can_accept;
    logic             transfer;
    logic             consume;
    logic             sel;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_next;
    logic             ovf_next;

    logic             res_valid_reg;
    logic [WIDTH-1:0] res_sum_reg;
    logic             res_overflow_reg;
    logic             res_id_reg;
    logic             last_grant_reg;
    logic [3:0]       ovf_count_reg;

    assign valid_vec  = {req1_valid, req0_valid};
    assign can_accept = !res_valid_reg || res_ready;

    // Round-robin: on contention the requester that did not win last time is granted.
    always_comb begin
        grant = 2'b00;
        case (valid_vec)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Readies are also gated by rst_n so nothing is offered while reset is held.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign ready_vec[gi] = grant[gi] & can_accept & rst_n;
            assign xfer_vec[gi]  = valid_vec[gi] & ready_vec[gi];
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];
    assign transfer   = |xfer_vec;
    assign consume    = res_valid_reg & res_ready;

    assign sel      = grant[1];
    assign op_a     = sel ? req1_a : req0_a;
    assign op_b     = sel ? req1_b : req0_b;
    assign sum_next = op_a + op_b;
    assign ovf_next = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_next[WIDTH-1] != op_a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_reg    <= 1'b0;
            res_sum_reg      <= '0;
            res_overflow_reg <= 1'b0;
            res_id_reg       <= 1'b0;
            last_grant_reg   <= 1'b1;
            ovf_count_reg    <= 4'd0;
        end else begin
            if (transfer) begin
                res_valid_reg    <= 1'b1;
                res_sum_reg      <= sum_next;
                res_overflow_reg <= ovf_next;
                res_id_reg       <= sel;
                last_grant_reg   <= sel;
            end else if (consume) begin
                res_valid_reg <= 1'b0;
            end

            if (ovf_clr) begin
                ovf_count_reg <= 4'd0;
            end else if (consume && res_overflow_reg && (ovf_count_reg != 4'd15)) begin
                ovf_count_reg <= ovf_count_reg + 4'd1;
            end
        end
    end

    assign res_valid    = res_valid_reg;
    assign res_sum      = res_sum_reg;
    assign res_overflow = res_overflow_reg;
    assign res_id       = res_id_reg;
    assign ovf_count    = ovf_count_reg;

endmodule
